// File: rtl/reg_cmd_pkg.sv
// reg_cmd_pkg: definitions shared by the register-command encoder (reg_cmd_enc)
// and the slave-side decoder.
//   state_t / ST_*         : encoder FSM state encoding
//   CMD_*                  : bit positions inside the command byte
//   DUMMY_BYTE             : filler byte sent and returned when no data is carried
//   pack_cmd()             : builds a command byte from its fields
package reg_cmd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CMD     = 3'd1;
    localparam state_t ST_CMD_RX  = 3'd2;
    localparam state_t ST_DATA    = 3'd3;
    localparam state_t ST_DATA_RX = 3'd4;
    localparam state_t ST_GAP     = 3'd5;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_HI_BIT   = 6;
    localparam int CMD_ADDR_MSB = 5;
    localparam int CMD_ADDR_LSB = 0;

    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    function automatic logic [7:0] pack_cmd(input logic       write,
                                            input logic       hi,
                                            input logic [5:0] addr);
        logic [7:0] b;
        b                            = DUMMY_BYTE;
        b[CMD_RW_BIT]                = write;
        b[CMD_HI_BIT]                = hi;
        b[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
        return b;
    endfunction

endpackage

// File: rtl/reg_cmd_enc.sv
// reg_cmd_enc: turns single-byte register read/write requests into two-byte SPI
// frames (command byte, then data byte) and reports completion.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake; req_write, req_hi, req_addr,
//                              req_wdata are latched on acceptance
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err         read data / timeout flag, held until next response
//   cs_n                       SPI frame select, active-low
//   tx_valid/tx_data/tx_ready  byte to SPI master
//   rx_valid/rx_data           byte received by SPI master
//
// Parameters
//   GAP_CYCLES      cycles cs_n stays high between back-to-back frames (1..255)
//   TIMEOUT_CYCLES  RX wait limit (1..256), only acted on with the macro below
//
// Build option
//   REG_CMD_ENC_TIMEOUT_EN  when defined, an RX state that waits TIMEOUT_CYCLES
//                           without rx_valid ends the frame with rsp_err=1.
//                           Otherwise RX states wait forever and rsp_err is 0.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | ready for a request, cs_n high
// CMD        | presenting command byte on tx, waiting for tx_ready
// CMD_RX     | waiting for the (discarded) byte clocked in with the command
// DATA       | presenting write data / dummy byte, waiting for tx_ready
// DATA_RX    | waiting for the returned data byte
// GAP        | cs_n high for GAP_CYCLES cycles before the next frame
module reg_cmd_enc
    import reg_cmd_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_hi,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       cs_n,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       write_q, hi_q;
    logic [5:0] addr_q;
    logic [7:0] wdata_q;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       accept, in_frame, cnt_tc, timeout_fire;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && (state_q == ST_IDLE);
    assign cnt_tc    = (cnt_q == 8'd0);
    assign in_frame  = (state_q == ST_CMD)  || (state_q == ST_CMD_RX) ||
                       (state_q == ST_DATA) || (state_q == ST_DATA_RX);

`ifdef REG_CMD_ENC_TIMEOUT_EN
    assign timeout_fire = cnt_tc && !rx_valid;
`else
    assign timeout_fire = 1'b0;
`endif

    // cs_n drops already in the accepting IDLE cycle so that the high time
    // between back-to-back frames equals the GAP length exactly.
    assign cs_n     = !(in_frame || (accept && rst_n));
    assign tx_valid = (state_q == ST_CMD) || (state_q == ST_DATA);

    always_comb begin
        tx_data = DUMMY_BYTE;
        if (state_q == ST_CMD)
            tx_data = pack_cmd(write_q, hi_q, addr_q);
        else if (state_q == ST_DATA && write_q)
            tx_data = wdata_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (tx_ready) begin
                    state_d = ST_CMD_RX;
                    cnt_d   = TMO_LOAD;
                end
            end
            ST_CMD_RX: begin
                if (rx_valid) begin
                    state_d = ST_DATA;
                end else if (timeout_fire) begin
                    state_d     = ST_GAP;
                    cnt_d       = GAP_LOAD;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = DUMMY_BYTE;
                end else if (!cnt_tc) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DATA: begin
                if (tx_ready) begin
                    state_d = ST_DATA_RX;
                    cnt_d   = TMO_LOAD;
                end
            end
            ST_DATA_RX: begin
                if (rx_valid) begin
                    state_d     = ST_GAP;
                    cnt_d       = GAP_LOAD;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? DUMMY_BYTE : rx_data;
                end else if (timeout_fire) begin
                    state_d     = ST_GAP;
                    cnt_d       = GAP_LOAD;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = DUMMY_BYTE;
                end else if (!cnt_tc) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_tc) state_d = ST_IDLE;
                else        cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            write_q     <= 1'b0;
            hi_q        <= 1'b0;
            addr_q      <= 6'd0;
            wdata_q     <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                write_q <= req_write;
                hi_q    <= req_hi;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef REG_CMD_ENC_TIMEOUT_EN
    logic rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           rsp_err_q <= 1'b0;
        else if (rsp_valid_d) rsp_err_q <= timeout_fire;
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_cmd_enc.sv
// tb_reg_cmd_enc: randomized self-checking bench for reg_cmd_enc.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A queue-based model holds the expected tx bytes and responses.
// Define REG_CMD_ENC_TIMEOUT_EN for both RTL and bench to exercise the timeout.
module tb_reg_cmd_enc;

    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write, req_hi;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       cs_n, tx_valid, tx_ready, rx_valid;
    logic [7:0] tx_data, rx_data;

    always #5 clk = ~clk;

    reg_cmd_enc #(.GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_hi(req_hi), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cs_n(cs_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];
    int         rsp_seen    = 0;
    int         cyc         = 0;
    int         hi_run      = 0;
    int         last_hi_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every tx handshake and every response is matched in order.
    always @(negedge clk) begin
        rsp_t r;
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) check("tx_unexpected", 32'(exp_tx.size()), 32'd1);
            else                    check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (rsp_valid) begin
            rsp_seen++;
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 32'(exp_rsp.size()), 32'd1);
            end else begin
                r = exp_rsp.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                check("rsp_err", 32'(rsp_err), 32'(r.err));
            end
        end
        if (cs_n) hi_run++;
        else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end
    end

    function automatic logic [7:0] model_cmd(input bit wr, input bit hi, input int addr);
        return 8'(wr * 128 + hi * 64 + addr);
    endfunction

    // Presents one byte; tx_ready is withheld for wait_n cycles.
    task automatic tx_phase(input int wait_n);
        logic [7:0] first;
        first = 8'h00;
        for (int i = 0; i <= wait_n; i++) begin
            tx_ready = (i == wait_n);
            @(negedge clk);
            if (i == 0) first = tx_data;
            else        check("tx_stable", 32'(tx_data), 32'(first));
            check("tx_valid_hi", 32'(tx_valid), 32'd1);
            check("cs_n_frame", 32'(cs_n), 32'd0);
            check("req_ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
    endtask

    // Returns a byte after wait_n idle cycles carrying junk on rx_data.
    task automatic rx_phase(input int wait_n, input logic [7:0] b);
        for (int i = 0; i <= wait_n; i++) begin
            rx_valid = (i == wait_n);
            rx_data  = (i == wait_n) ? b : 8'($urandom);
            @(negedge clk);
            check("tx_valid_lo", 32'(tx_valid), 32'd0);
            check("cs_n_frame_rx", 32'(cs_n), 32'd0);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    // Raises a request and holds it until accepted; returns the accept cycle.
    task automatic start_req(input bit wr, input bit hi, input logic [5:0] addr,
                             input logic [7:0] wd, output int c0);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_hi    = hi;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        check("cs_n_accept", 32'(cs_n), 32'd0);
        c0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_hi    = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = 8'($urandom);
    endtask

    task automatic run_frame(input bit wr, input bit hi, input logic [5:0] addr,
                             input logic [7:0] wd, input logic [7:0] rxb,
                             input int tw1, input int rw1, input int tw2, input int rw2,
                             input bit b2b);
        int   c0;
        rsp_t r;
        exp_tx.push_back(model_cmd(wr, hi, int'(addr)));
        exp_tx.push_back(wr ? wd : 8'h00);
        r.rdata = wr ? 8'h00 : rxb;
        r.err   = 1'b0;
        exp_rsp.push_back(r);
        start_req(wr, hi, addr, wd, c0);
        if (b2b) check("gap_len", 32'(last_hi_run), 32'(GAP_CYCLES));
        tx_phase(tw1);
        rx_phase(rw1, 8'($urandom));
        tx_phase(tw2);
        rx_phase(rw2, rxb);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("cs_n_rsp", 32'(cs_n), 32'd1);
        check("req_ready_gap", 32'(req_ready), 32'd0);
        if (tw1 + rw1 + tw2 + rw2 == 0) check("latency", 32'(cyc - c0), 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("rsp_hold", 32'(rsp_rdata), 32'(r.rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, n, seen0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_hi    = 1'b0;
        req_addr  = 6'd0;
        req_wdata = 8'd0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_frame(1'b1, 1'b0, 6'h05, 8'hA5, 8'h5A, 0, 0, 0, 0, 1'b0);
        run_frame(1'b0, 1'b1, 6'h12, 8'h00, 8'h3C, 0, 0, 0, 0, 1'b1);
        run_frame(1'b1, 1'b0, 6'h05, 8'hA5, 8'hC3, 10, 0, 0, 0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            run_frame(1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in the middle of DATA_RX: no response may follow.
        exp_tx.push_back(model_cmd(1'b0, 1'b0, 6'h2A));
        exp_tx.push_back(8'h00);
        start_req(1'b0, 1'b0, 6'h2A, 8'h00, c0);
        tx_phase(0);
        rx_phase(0, 8'h11);
        tx_phase(1);
        @(negedge clk);
        check("cs_n_data_rx", 32'(cs_n), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'h00);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_rdata", 32'(rsp_rdata), 32'h00);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        seen0 = rsp_seen;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("no_rsp_after_reset", 32'(rsp_seen), 32'(seen0));
        check("cs_n_after_reset", 32'(cs_n), 32'd1);
        check("req_ready_after_reset", 32'(req_ready), 32'd1);

        run_frame(1'b0, 1'b1, 6'h3F, 8'h00, 8'hE7, 0, 0, 0, 0, 1'b0);

`ifdef REG_CMD_ENC_TIMEOUT_EN
        begin
            rsp_t r;
            exp_tx.push_back(model_cmd(1'b0, 1'b0, 6'h05));
            r.rdata = 8'h00;
            r.err   = 1'b1;
            exp_rsp.push_back(r);
            start_req(1'b0, 1'b0, 6'h05, 8'h00, c0);
            tx_phase(0);
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < TIMEOUT_CYCLES + 50) begin
                n++;
                @(posedge clk); #1;
                @(negedge clk);
            end
            check("timeout_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
            check("timeout_err", 32'(rsp_err), 32'd1);
            check("timeout_cs_n", 32'(cs_n), 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            run_frame(1'b1, 1'b1, 6'h21, 8'h96, 8'h00, 0, 0, 0, 0, 1'b1);
        end
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_cmd_enc.md
REG_CMD_ENC -- requirements
Module: reg_cmd_enc

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: clk cycles cs_n stays high between frames (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: RX wait limit, used only with REG_CMD_ENC_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  register access request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_hi  input  1  1 = high byte, 0 = low byte.
REQ-009 SHALL have port req_addr  input  6  register address.
REQ-010 SHALL have port req_wdata  input  8  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-012 SHALL have port rsp_rdata  output  8  read data; 0x00 for writes.
REQ-013 SHALL have port rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-014 SHALL have port cs_n  output  1  SPI frame select, active-low.
REQ-015 SHALL have port tx_valid, tx_data  output  1/8  byte to SPI master.
REQ-016 SHALL have port tx_ready  input  1  SPI master accepts byte.
REQ-017 SHALL have port rx_valid, rx_data  input  1/8  byte received by SPI master.

Function
REQ-018 SHALL implement states IDLE, CMD, CMD_RX, DATA, DATA_RX, GAP.
REQ-019 SHALL drive req_ready = (state == IDLE); on req_valid&req_ready latch all req_* fields, drive cs_n low, enter CMD.
REQ-020 In CMD SHALL drive tx_valid=1, tx_data={write,hi,addr}; on tx_ready enter CMD_RX.
REQ-021 In CMD_RX SHALL discard rx_data on rx_valid and enter DATA.
REQ-022 In DATA SHALL drive tx_valid=1, tx_data=wdata (write) or 0x00 (read); on tx_ready enter DATA_RX.
REQ-023 In DATA_RX, on rx_valid, SHALL drive next cycle rsp_valid=1, rsp_rdata=rx_data (read) or 0x00 (write), rsp_err=0, cs_n high; enter GAP.
REQ-024 tx_valid and tx_data SHALL stay stable until tx_ready; tx_valid SHALL be 0 outside CMD/DATA.
REQ-025 rx_valid outside CMD_RX/DATA_RX SHALL be ignored.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles with cs_n high, then enter IDLE.
REQ-027 rsp_valid SHALL be high exactly one cycle per accepted request; rsp_rdata/rsp_err SHALL hold until the next response.
REQ-028 Request-to-rsp_valid latency SHALL be 5 cycles when tx_ready and rx_valid respond with zero wait.

Reset
REQ-029 On rst_n low, at any time including mid-frame, SHALL enter IDLE with cs_n=1, tx_valid=0, tx_data=0x00, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, counters cleared.
REQ-030 A frame interrupted by reset SHALL produce no rsp_valid.

Configuration
REQ-031 With REG_CMD_ENC_TIMEOUT_EN defined, a counter SHALL run in CMD_RX/DATA_RX; on reaching TIMEOUT_CYCLES without rx_valid SHALL pulse rsp_valid with rsp_err=1, rsp_rdata=0x00, cs_n high, enter GAP.
REQ-032 Without REG_CMD_ENC_TIMEOUT_EN, RX states SHALL wait indefinitely and rsp_err SHALL be constant 0.

Structure
REQ-033 Shared package reg_cmd_pkg SHALL hold the state type, command-byte field positions (RW bit 7, HI bit 6, ADDR 5:0) and DUMMY_BYTE = 0x00, shared with the slave-side decoder.
REQ-034 No sub-module; gap and timeout SHALL share one 8-bit internal counter.

Verification
REQ-035 Write addr 0x05 hi=0 wdata 0xA5 -> tx bytes 0x85 then 0xA5; rsp_valid with rdata 0x00, err 0.
REQ-036 Read addr 0x12 hi=1, second rx byte 0x3C -> tx bytes 0x52 then 0x00; rsp_rdata=0x3C.
REQ-037 tx_ready held low 10 cycles in CMD -> tx_valid=1, tx_data=0x85 stable, cs_n low throughout.
REQ-038 Back-to-back requests -> cs_n high exactly 2 cycles between frames; req_ready low from accept until IDLE.
REQ-039 rst_n pulsed low in DATA_RX -> cs_n=1, tx_valid=0 immediately; no rsp_valid afterwards.
REQ-040 With REG_CMD_ENC_TIMEOUT_EN, rx_valid withheld in CMD_RX -> rsp_valid with rsp_err=1 after 255 cycles.
